mem_arbiter: RTL

Shares the single block-wide main-memory port between I-cache read misses and D-cache read/write misses. Sits between both caches and the memory models; the memory side has a 20-cycle latency.
- Latches one request, issues it as a one-cycle strobe, waits for the memory ready pulse, then returns the block to the owner with a one-cycle ready pulse.
- Forwards I-side aborts (wrong-path fetch after branch) to memory.
- Flags memory timeouts.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_select.sv | 51 +++++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } arb_state_t;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   localparam int unsigned DEFAULT_BLOCK_SIZE = 32'h80;
   localparam int unsigned DEFAULT_TIMEOUT    = 64;

endpackage

// File: rtl/arb_select.sv
// Request selection between I-cache and D-cache misses.
// ARB_ROUND_ROBIN_EN: when defined, a simultaneous I/D request goes to the
// side that was not granted last; otherwise D always beats I.
module arb_select
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic i_abort,
   input  logic last_owner,
   output logic grant_valid,
   output logic grant_owner
);

   logic i_ok;

   // An aborted I request is never granted.
   assign i_ok = i_req & ~i_abort;

`ifndef ARB_ROUND_ROBIN_EN
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
`endif

   // Pick the winner among the live requests.
   always_comb begin
      grant_valid = 1'b0;
      grant_owner = OWNER_I;
`ifdef ARB_ROUND_ROBIN_EN
      if (d_req && i_ok) begin
         grant_valid = 1'b1;
         grant_owner = (last_owner == OWNER_D) ? OWNER_I : OWNER_D;
      end else if (d_req) begin
         grant_valid = 1'b1;
         grant_owner = OWNER_D;
      end else if (i_ok) begin
         grant_valid = 1'b1;
         grant_owner = OWNER_I;
      end
`else
      if (d_req) begin
         grant_valid = 1'b1;
         grant_owner = OWNER_D;
      end else if (i_ok) begin
         grant_valid = 1'b1;
         grant_owner = OWNER_I;
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the block-wide main-memory port between I-cache read misses and
// D-cache read/write misses. One transaction at a time: latch, strobe,
// wait for mem_ready, pulse ready back to the owner.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating priority on ties).
//
// state | meaning
// IDLE  | no transaction; select and latch a request
// ISSUE | one-cycle mem_read/mem_write strobe from the latches
// WAIT  | waiting for mem_ready; I abort or timeout drops back to IDLE
// RESP  | one-cycle i_ready/d_ready pulse to the owner
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
   parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    i_req,
   input  logic [31:0]             i_addr,
   input  logic                    i_abort,
   output logic                    i_ready,
   output logic [32*BLOCK_SIZE-1:0] i_data,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [31:0]             d_addr,
   input  logic [32*BLOCK_SIZE-1:0] d_wdata,
   output logic                    d_ready,
   output logic [32*BLOCK_SIZE-1:0] d_rdata,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [31:0]             mem_addr,
   output logic [32*BLOCK_SIZE-1:0] mem_wdata,
   output logic                    mem_abort,
   input  logic                    mem_ready,
   input  logic [32*BLOCK_SIZE-1:0] mem_rdata,
   output logic                    owner,
   output logic                    busy,
   output logic                    err
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   arb_state_t state, state_nxt;
   logic       we_q;
   logic [7:0] tmo_cnt;
   logic       grant_valid, grant_owner;
   logic       grant_take, capture, timeout_hit;
   logic       last_owner;
   logic       i_abort_own;

   arb_select u_sel (
      .i_req       (i_req),
      .d_req       (d_req),
      .i_abort     (i_abort),
      .last_owner  (last_owner),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

`ifdef ARB_ROUND_ROBIN_EN
   // Remember which side was granted last for tie-breaking.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         last_owner <= OWNER_I;
      else if (grant_take)
         last_owner <= grant_owner;
   end
`else
   assign last_owner = OWNER_I;
`endif

   assign busy        = (state != IDLE);
   assign i_abort_own = (owner == OWNER_I) && i_abort;

   // State register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and strobe/pulse decode.
   always_comb begin
      state_nxt   = state;
      grant_take  = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_abort   = 1'b0;
      i_ready     = 1'b0;
      d_ready     = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               grant_take = 1'b1;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            // An I abort here never reaches memory, so no mem_abort either.
            if (i_abort_own) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WAIT;
               if ((owner == OWNER_D) && we_q)
                  mem_write = 1'b1;
               else
                  mem_read = 1'b1;
            end
         end
         WAIT: begin
            // Abort outranks a coincident mem_ready; the data is dropped.
            if (i_abort_own) begin
               mem_abort = 1'b1;
               state_nxt = IDLE;
            end else if (mem_ready) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else if (tmo_cnt == TMO_LAST) begin
               mem_abort   = 1'b1;
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         RESP: begin
            i_ready   = (owner == OWNER_I);
            d_ready   = (owner == OWNER_D);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latches, owner and return-data capture.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         owner     <= OWNER_I;
         we_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_data    <= '0;
         d_rdata   <= '0;
      end else begin
         if (grant_take) begin
            owner <= grant_owner;
            if (grant_owner == OWNER_D) begin
               mem_addr  <= d_addr;
               we_q      <= d_we;
               mem_wdata <= d_wdata;
            end else begin
               mem_addr <= i_addr;
               we_q     <= 1'b0;
            end
         end
         if (capture) begin
            if (owner == OWNER_I)
               i_data <= mem_rdata;
            else if (!we_q)
               d_rdata <= mem_rdata;
         end
      end
   end

   // WAIT-cycle counter and sticky timeout flag.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         tmo_cnt <= '0;
         err     <= 1'b0;
      end else begin
         if (state == ISSUE)
            tmo_cnt <= '0;
         else if (state == WAIT)
            tmo_cnt <= tmo_cnt + 8'd1;
         if (timeout_hit)
            err <= 1'b1;
      end
   end

endmodule
